// File: rtl/frame_plotter.sv
// rtl/frame_plotter.sv - scans a 16x32 bitmap into VGA pixel writes, skipping unchanged pixels
module frame_plotter #(
  parameter logic [2:0] FG_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_start,
  input  logic         i_full_redraw,
  input  logic [511:0] i_display,
  output logic [3:0]   o_x,
  output logic [4:0]   o_y,
  output logic [2:0]   o_colour,
  output logic         o_plot,
  output logic         o_busy,
  output logic         o_done,
  output logic [9:0]   o_plot_count
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [8:0]   r_idx;
  logic [511:0] r_snap;
  logic [511:0] r_shadow;
  logic         r_shadow_valid;
  logic         r_full;
  logic [9:0]   r_cnt;
  logic [3:0]   r_x;
  logic [4:0]   r_y;
  logic [2:0]   r_colour;
  logic         r_plot;
  logic [9:0]   r_plot_count;

  logic         w_emit;
  logic [8:0]   w_emit_idx;
  logic         w_emit_full;
  logic         w_emit_bit;
  logic         w_emit_plot;

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // The output registers lead r_idx by one: pixel 0 is emitted on the accepting edge.
  always_comb begin
    w_next      = r_state;
    w_emit      = 1'b0;
    w_emit_idx  = r_idx + 9'd1;
    w_emit_full = r_full;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_next      = SCAN;
          w_emit      = 1'b1;
          w_emit_idx  = 9'd0;
          w_emit_full = i_full_redraw;
        end
      end
      SCAN: begin
        if (r_idx == 9'd511) w_next = DONE;
        else                 w_emit = 1'b1;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_emit_bit  = (r_state == IDLE) ? i_display[w_emit_idx] : r_snap[w_emit_idx];
  assign w_emit_plot = w_emit_full | ~r_shadow_valid | (w_emit_bit != r_shadow[w_emit_idx]);

  always_ff @(posedge clock) begin
    if (r_state == IDLE && i_start) r_snap <= i_display;
    if (w_emit) r_shadow[w_emit_idx] <= w_emit_bit;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_idx          <= 9'd0;
      r_full         <= 1'b0;
      r_cnt          <= 10'd0;
      r_x            <= 4'd0;
      r_y            <= 5'd0;
      r_colour       <= BG_COLOUR;
      r_plot         <= 1'b0;
      r_plot_count   <= 10'd0;
      r_shadow_valid <= 1'b0;
    end else begin
      r_plot <= w_emit & w_emit_plot;
      if (r_state == IDLE && i_start) r_full <= i_full_redraw;
      if (w_emit) begin
        r_idx    <= w_emit_idx;
        r_x      <= w_emit_idx[8:5];
        r_y      <= w_emit_idx[4:0];
        r_colour <= w_emit_bit ? FG_COLOUR : BG_COLOUR;
        r_cnt    <= ((r_state == IDLE) ? 10'd0 : r_cnt) + {9'd0, w_emit_plot};
      end
      if (r_state == SCAN && w_next == DONE) begin
        r_plot_count   <= r_cnt;
        r_shadow_valid <= 1'b1;
      end
    end
  end

  assign o_x          = r_x;
  assign o_y          = r_y;
  assign o_colour     = r_colour;
  assign o_plot       = r_plot;
  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == DONE);
  assign o_plot_count = r_plot_count;

endmodule

// File: tb/tb_frame_plotter.sv
// tb/tb_frame_plotter.sv - frame_plotter bench: vector table plus plot scoreboard
module tb_frame_plotter;

  logic         clock = 1'b0;
  logic         resetn;
  logic         start;
  logic         full_redraw;
  logic [511:0] display;
  logic [3:0]   o_x;
  logic [4:0]   o_y;
  logic [2:0]   o_colour;
  logic         o_plot;
  logic         o_busy;
  logic         o_done;
  logic [9:0]   o_plot_count;

  always #5 clock = ~clock;

  frame_plotter dut (
    .clock        (clock),
    .resetn       (resetn),
    .i_start      (start),
    .i_full_redraw(full_redraw),
    .i_display    (display),
    .o_x          (o_x),
    .o_y          (o_y),
    .o_colour     (o_colour),
    .o_plot       (o_plot),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_plot_count (o_plot_count)
  );

  typedef struct {
    int         k;
    logic [2:0] colour;
  } plot_t;

  typedef struct {
    logic [511:0] disp;
    logic         fr;
    logic         hold;
    logic         pre;
    int           toggle_at;
    int           exp_count;
  } vec_t;

  plot_t        sb[$];
  vec_t         tbl[7];
  logic [511:0] m_shadow;
  logic         m_valid;
  int           prev_count;
  int           n_cmp;
  int           n_fail;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_frame(input logic [511:0] disp, input logic fr, input logic hold,
                           input logic pre, input int toggle_at, input int exp_count);
    plot_t      e;
    logic       exp_plot;
    logic [8:0] kk;
    logic [2:0] ec;
    for (int k = 0; k < 512; k++) begin
      if (fr || !m_valid || (disp[k] != m_shadow[k])) begin
        e.k      = k;
        e.colour = disp[k] ? 3'b111 : 3'b000;
        sb.push_back(e);
      end
      m_shadow[k] = disp[k];
    end
    if (!pre) begin
      @(negedge clock);
      display     = disp;
      full_redraw = fr;
      start       = 1'b1;
    end
    for (int c = 1; c <= 514; c++) begin
      @(negedge clock);
      chk("busy", int'(o_busy), int'(c <= 513));
      chk("done", int'(o_done), int'(c == 513));
      if (c <= 512) begin
        kk       = 9'(c - 1);
        ec       = disp[kk] ? 3'b111 : 3'b000;
        exp_plot = (sb.size() > 0) && (sb[0].k == c - 1);
        chk("plot", int'(o_plot), int'(exp_plot));
        chk("pixel", int'({o_x, o_y, o_colour}), int'({kk[8:5], kk[4:0], ec}));
        if (exp_plot) begin
          e = sb.pop_front();
          chk("sb_colour", int'(o_colour), int'(e.colour));
        end
      end else begin
        chk("plot_idle", int'(o_plot), 0);
        chk("xy_hold", int'({o_x, o_y}), int'({4'd15, 5'd31}));
      end
      if (c == 1) chk("count_hold", int'(o_plot_count), prev_count);
      if (c >= 513) chk("plot_count", int'(o_plot_count), exp_count);
      if (c == 1 && !hold) start = 1'b0;
      if (c == toggle_at) display = '1;
    end
    m_valid    = 1'b1;
    prev_count = exp_count;
  endtask

  initial begin
    logic [511:0] one_px;
    logic [511:0] pattern;
    int           done_seen;
    int           busy_seen;
    n_cmp = 0; n_fail = 0;
    m_valid = 1'b0; m_shadow = '0; prev_count = 0;
    resetn = 1'b0; start = 1'b0; full_redraw = 1'b0; display = '0;
    one_px = '0;
    one_px[32*3+5] = 1'b1;
    pattern = {16{32'hAAAA5555}};

    tbl[0] = '{'0,      1'b0, 1'b0, 1'b0, 0,  512};
    tbl[1] = '{'0,      1'b0, 1'b0, 1'b0, 0,  0};
    tbl[2] = '{one_px,  1'b0, 1'b0, 1'b0, 0,  1};
    tbl[3] = '{one_px,  1'b1, 1'b0, 1'b0, 0,  512};
    tbl[4] = '{pattern, 1'b0, 1'b0, 1'b0, 0,  257};
    tbl[5] = '{'0,      1'b0, 1'b1, 1'b0, 10, 256};
    tbl[6] = '{'1,      1'b0, 1'b0, 1'b1, 0,  512};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_plot", int'(o_plot), 0);
    chk("rst_xy", int'({o_x, o_y}), 0);
    chk("rst_colour", int'(o_colour), 0);
    chk("rst_count", int'(o_plot_count), 0);
    resetn = 1'b1;

    for (int i = 0; i < 7; i++)
      run_frame(tbl[i].disp, tbl[i].fr, tbl[i].hold, tbl[i].pre, tbl[i].toggle_at, tbl[i].exp_count);

    @(negedge clock);
    display = '1; full_redraw = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (100) @(negedge clock);
    chk("busy_before_abort", int'(o_busy), 1);
    resetn = 1'b0;
    @(negedge clock);
    chk("abort_busy", int'(o_busy), 0);
    chk("abort_done", int'(o_done), 0);
    chk("abort_plot", int'(o_plot), 0);
    chk("abort_xy", int'({o_x, o_y}), 0);
    chk("abort_colour", int'(o_colour), 0);
    chk("abort_count", int'(o_plot_count), 0);
    resetn = 1'b1;
    done_seen = 0; busy_seen = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (o_done) done_seen++;
      if (o_busy) busy_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_no_busy", busy_seen, 0);
    m_valid = 1'b0;
    prev_count = 0;
    run_frame('1, 1'b0, 1'b0, 1'b0, 0, 512);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_plotter.md
FRAME_PLOTTER -- requirements
Module: frame_plotter

Interface
REQ-001 Parameter FG_COLOUR, default 3'b111, colour driven for a set (1) pixel.
REQ-002 Parameter BG_COLOUR, default 3'b000, colour driven for a clear (0) pixel.
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 start  input  1  request to draw the current display bitmap; sampled every cycle.
REQ-006 full_redraw  input  1  when high at accepted start, plot every pixel regardless of change.
REQ-007 display  input  512  16x32 bitmap; pixel (x,y) = display[32*x + y].
REQ-008 x  output  4  pixel column to the VGA adapter.
REQ-009 y  output  5  pixel row to the VGA adapter.
REQ-010 colour  output  3  pixel colour to the VGA adapter.
REQ-011 plot  output  1  write strobe; x, y, colour valid in the same cycle.
REQ-012 busy  output  1  high while a frame is being scanned or completing.
REQ-013 done  output  1  one-cycle pulse at frame completion.
REQ-014 plot_count  output  10  number of plot strobes issued in the most recently completed frame.

Function
REQ-015 The block SHALL implement states IDLE, SCAN, DONE; IDLE->SCAN on start while IDLE, SCAN->DONE after pixel (15,31), DONE->IDLE unconditionally.
REQ-016 On accepted start (cycle N), the block SHALL capture display into a 512-bit snapshot and latch full_redraw; later display/full_redraw changes SHALL NOT affect the frame.
REQ-017 start while busy SHALL be ignored, with no queuing.
REQ-018 SCAN SHALL visit one pixel per cycle, y fastest (0..31), then x (0..15); pixel k emitted in cycle N+1+k, k = 0..511.
REQ-019 For each visited pixel, plot SHALL be 1 iff the latched full_redraw is set, the shadow is invalid, or the snapshot bit differs from the shadow bit.
REQ-020 colour SHALL be FG_COLOUR for snapshot bit 1, else BG_COLOUR; x, y, colour SHALL be registered and SHALL track the visited pixel even when plot is 0.
REQ-021 A 512-bit shadow SHALL hold the last drawn frame; each visited pixel's shadow bit SHALL be updated with its snapshot bit; shadow becomes valid at SCAN->DONE.
REQ-022 done SHALL be 1 only in cycle N+513 (DONE); busy SHALL be 1 in cycles N+1..N+513; a start in N+514 SHALL be accepted.
REQ-023 An internal counter SHALL count plots in the frame (0..512, 10 bits, no wrap); plot_count SHALL load it at DONE and hold until the next DONE.
REQ-024 Outside SCAN, plot SHALL be 0; x, y SHALL hold their last values.

Reset
REQ-025 While resetn is 0 at a clock edge: state=IDLE, x=0, y=0, colour=BG_COLOUR, plot=0, busy=0, done=0, plot_count=0, shadow invalid.
REQ-026 Reset asserted mid-SCAN SHALL abort the frame without done; the next frame SHALL be a full redraw (512 plots).

Verification
REQ-027 Reset, display all 0, start pulse at cycle N -> 512 plots cycles N+1..N+512, colour 000, done at N+513, plot_count=512.
REQ-028 Repeat same frame, full_redraw=0 -> zero plots, done at N+513, plot_count=0, busy high N+1..N+513.
REQ-029 Set display[32*3+5]=1 only, start -> single plot at x=3, y=5, colour 111 in cycle N+1+(3*32+5)=N+102, plot_count=1.
REQ-030 start held high through a frame and display toggled to all 1s at N+10 -> second start accepted only at N+514; first frame plots reflect snapshot at N only.
REQ-031 resetn low at N+101 for one cycle -> outputs at reset values, no done; next start with unchanged display -> 512 plots, plot_count=512.
REQ-032 Identical frame with full_redraw=1 -> 512 plots, colours match snapshot, plot_count=512.
